// File: rtl/cci_mpf_rd_arb_pkg.sv
// Shared types and constants for the CCI-P c0 read-request arbiter.
package cci_mpf_rd_arb_pkg;

    // Upper bound on requesters; sizes the client-id type used by reusable logic.
    localparam int unsigned MAX_CLIENTS = 16;
    localparam int unsigned CLIENT_ID_W = $clog2(MAX_CLIENTS);
    typedef logic [CLIENT_ID_W-1:0] t_client_id;

    // Widest outstanding-line counter any configuration needs.
    localparam int unsigned ACTIVE_CNT_W_MAX = 16;
    typedef logic [ACTIVE_CNT_W_MAX-1:0] t_active_cnt;

    // A counter must hold MAX_ACTIVE itself, so it needs one bit beyond clog2.
    function automatic int unsigned active_cnt_width(input int unsigned max_active);
        return $clog2(max_active) + 1;
    endfunction

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DRAIN   = 2'd1,
        DRAINED = 2'd2
    } t_rd_arb_state;

    // Three-line bursts do not exist on CCI-P.
    localparam logic [1:0] CL_LEN_ILLEGAL = 2'b10;

endpackage

// File: rtl/cci_mpf_rd_arb_if.sv
// Client-side request bus, FIU-side request bus and response return path.
interface cci_mpf_rd_arb_if #(
    parameter int unsigned N_CLIENTS = 4,
    parameter int unsigned REQ_WIDTH = 64
);
    localparam int unsigned ID_W = $clog2(N_CLIENTS);

    logic [N_CLIENTS-1:0]                req_valid;
    logic [N_CLIENTS-1:0][REQ_WIDTH-1:0] req_data;
    logic [N_CLIENTS-1:0][1:0]           req_cl_len;
    logic [N_CLIENTS-1:0]                req_grant;
    logic                                fiu_almost_full;
    logic                                out_valid;
    logic [REQ_WIDTH-1:0]                out_data;
    logic [1:0]                          out_cl_len;
    logic [ID_W-1:0]                     out_client_id;
    logic                                rsp_valid;
    logic [ID_W-1:0]                     rsp_client_id;

    // Arbiter side.
    modport slave (
        input  req_valid, req_data, req_cl_len, fiu_almost_full, rsp_valid, rsp_client_id,
        output req_grant, out_valid, out_data, out_cl_len, out_client_id
    );

    // Clients, FIU and response decoder side.
    modport master (
        output req_valid, req_data, req_cl_len, fiu_almost_full, rsp_valid, rsp_client_id,
        input  req_grant, out_valid, out_data, out_cl_len, out_client_id
    );
endinterface

// File: rtl/cci_mpf_rr_arb.sv
// N-way round-robin picker: first eligible requester at or after ptr_i wins.
// Purely combinational so it can also serve c1 write arbitration.
module cci_mpf_rr_arb #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         eligible_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         grant_o,
    output logic [$clog2(N)-1:0] grant_id_o,
    output logic                 grant_valid_o
);
    localparam int unsigned ID_W = $clog2(N);

    logic [ID_W-1:0] idx;

    // Scan upward from the pointer with wraparound and stop at the first hit.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves a latch.
        grant_o       = '0;
        grant_id_o    = '0;
        grant_valid_o = 1'b0;
        idx           = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = ((32'(ptr_i) + k) >= N) ? ID_W'(32'(ptr_i) + k - N) : ID_W'(32'(ptr_i) + k);
            if (!grant_valid_o && eligible_i[idx]) begin
                grant_valid_o = 1'b1;
                grant_o[idx]  = 1'b1;
                grant_id_o    = idx;
            end
        end
    end
endmodule

// File: rtl/cci_mpf_rd_arb.sv
// Credit-based round-robin arbiter for the CCI-P c0 read-request channel.
// Per-client outstanding-line counters bound response buffering; a drain FSM
// quiesces all reads. Optional per-client grant statistics are enabled by
// defining CCI_MPF_RD_ARB_STATS_EN.
module cci_mpf_rd_arb
    import cci_mpf_rd_arb_pkg::*;
#(
    parameter int unsigned N_CLIENTS             = 4,
    parameter int unsigned MAX_ACTIVE_PER_CLIENT = 128,
    parameter int unsigned REQ_WIDTH             = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    cci_mpf_rd_arb_if.slave        bus,
    input  logic                   drain_req,
    output logic                   drain_done,
    output logic [N_CLIENTS-1:0]   client_not_empty,
    output logic                   all_idle,
    output logic                   err_underflow
`ifdef CCI_MPF_RD_ARB_STATS_EN
    ,
    input  logic [$clog2(N_CLIENTS)-1:0] stats_sel,
    output logic [31:0]                  stats_grants
`endif
);
    localparam int unsigned ID_W  = $clog2(N_CLIENTS);
    localparam int unsigned CNT_W = active_cnt_width(MAX_ACTIVE_PER_CLIENT);

    logic [N_CLIENTS-1:0] eligible;
    logic [N_CLIENTS-1:0] grant;
    logic [ID_W-1:0]      grant_id;
    logic                 grant_valid;

    logic [CNT_W-1:0]     active_cnt_q [N_CLIENTS];
    logic [CNT_W-1:0]     active_cnt_d [N_CLIENTS];
    logic                 cnt_all_zero;
    t_rd_arb_state        state_q, state_d;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic                 err_underflow_q, err_underflow_d;

    logic                 out_valid_q;
    logic [REQ_WIDTH-1:0] out_data_q;
    logic [1:0]           out_cl_len_q;
    logic [ID_W-1:0]      out_client_id_q;
    logic                 drain_done_q;
    logic                 all_idle_q;
    logic [N_CLIENTS-1:0] client_not_empty_q;

    // A client may go only while running, with FIU room and credits for the whole burst.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            eligible[i] = bus.req_valid[i] && !bus.fiu_almost_full && !reset && (state_q == RUN) &&
                (({1'b0, active_cnt_q[i]} + (CNT_W+1)'(bus.req_cl_len[i]) + (CNT_W+1)'(1))
                 <= (CNT_W+1)'(MAX_ACTIVE_PER_CLIENT));
        end
    end

    cci_mpf_rr_arb #(.N(N_CLIENTS)) u_rr_arb (
        .eligible_i    (eligible),
        .ptr_i         (rr_ptr_q),
        .grant_o       (grant),
        .grant_id_o    (grant_id),
        .grant_valid_o (grant_valid)
    );

    // Credit counters, underflow flag and round-robin pointer next state.
    always_comb begin
        err_underflow_d = err_underflow_q;
        cnt_all_zero    = 1'b1;
        rr_ptr_d        = rr_ptr_q;
        if (grant_valid) begin
            rr_ptr_d = (grant_id == ID_W'(N_CLIENTS - 1)) ? '0 : grant_id + ID_W'(1);
        end
        for (int i = 0; i < N_CLIENTS; i++) begin
            active_cnt_d[i] = active_cnt_q[i];
            if (active_cnt_q[i] != '0) cnt_all_zero = 1'b0;
            if (grant[i]) begin
                active_cnt_d[i] = active_cnt_q[i] + CNT_W'(bus.req_cl_len[i]) + CNT_W'(1);
            end
            // A response to an empty client is an error; the count stays pinned at zero.
            if (bus.rsp_valid && (bus.rsp_client_id == ID_W'(i))) begin
                if (active_cnt_q[i] == '0) err_underflow_d = 1'b1;
                else                       active_cnt_d[i] = active_cnt_d[i] - CNT_W'(1);
            end
        end
    end

    // Drain FSM next state; a dropped drain_req still completes through DRAINED.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (drain_req)                     state_d = DRAIN;
            DRAIN:   if (cnt_all_zero && !out_valid_q)  state_d = DRAINED;
            DRAINED: if (!drain_req)                    state_d = RUN;
            default:                                    state_d = RUN;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state always uses non-blocking assignment to avoid ordering races.
        if (reset) state_q <= RUN;
        else       state_q <= state_d;
    end

    // Credits, pointer, registered FIU request and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the counter array is architectural state, so every entry is reset explicitly.
            for (int i = 0; i < N_CLIENTS; i++) active_cnt_q[i] <= '0;
            rr_ptr_q           <= '0;
            err_underflow_q    <= 1'b0;
            out_valid_q        <= 1'b0;
            out_data_q         <= '0;
            out_cl_len_q       <= '0;
            out_client_id_q    <= '0;
            drain_done_q       <= 1'b0;
            all_idle_q         <= 1'b1;
            client_not_empty_q <= '0;
        end else begin
            for (int i = 0; i < N_CLIENTS; i++) begin
                active_cnt_q[i]       <= active_cnt_d[i];
                client_not_empty_q[i] <= (active_cnt_q[i] != '0);
            end
            rr_ptr_q        <= rr_ptr_d;
            err_underflow_q <= err_underflow_d;
            out_valid_q     <= grant_valid;
            if (grant_valid) begin
                out_data_q      <= bus.req_data[grant_id];
                out_cl_len_q    <= bus.req_cl_len[grant_id];
                out_client_id_q <= grant_id;
            end
            drain_done_q <= (state_q == DRAINED);
            all_idle_q   <= cnt_all_zero && !out_valid_q;
        end
    end

    assign bus.req_grant     = grant;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_data      = out_data_q;
    assign bus.out_cl_len    = out_cl_len_q;
    assign bus.out_client_id = out_client_id_q;
    assign drain_done        = drain_done_q;
    assign client_not_empty  = client_not_empty_q;
    assign all_idle          = all_idle_q;
    assign err_underflow     = err_underflow_q;

`ifdef CCI_MPF_RD_ARB_STATS_EN
    logic [31:0] grant_cnt_q [N_CLIENTS];
    logic [31:0] stats_grants_q;

    // Saturating per-client grant counters with a registered read port.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_CLIENTS; i++) grant_cnt_q[i] <= '0;
            stats_grants_q <= '0;
        end else begin
            for (int i = 0; i < N_CLIENTS; i++) begin
                if (grant[i] && (grant_cnt_q[i] != '1)) grant_cnt_q[i] <= grant_cnt_q[i] + 32'd1;
            end
            stats_grants_q <= grant_cnt_q[stats_sel];
        end
    end

    assign stats_grants = stats_grants_q;
`endif

endmodule

// File: tb/tb_cci_mpf_rd_arb.sv
// Self-checking bench for cci_mpf_rd_arb: directed scenarios plus a random run,
// all compared against a behavioural model and an output scoreboard.
module tb_cci_mpf_rd_arb;
    import cci_mpf_rd_arb_pkg::*;

    localparam int N   = 4;
    localparam int MAX = 128;
    localparam int W   = 64;

    logic clk = 1'b0;
    logic reset;
    logic drain_req;
    logic drain_done;
    logic all_idle;
    logic err_underflow;
    logic [N-1:0] client_not_empty;
`ifdef CCI_MPF_RD_ARB_STATS_EN
    logic [1:0]  stats_sel;
    logic [31:0] stats_grants;
`endif

    always #5 clk = ~clk;

    cci_mpf_rd_arb_if #(.N_CLIENTS(N), .REQ_WIDTH(W)) ifc ();

    cci_mpf_rd_arb #(.N_CLIENTS(N), .MAX_ACTIVE_PER_CLIENT(MAX), .REQ_WIDTH(W)) dut (
        .clk              (clk),
        .reset            (reset),
        .bus              (ifc),
        .drain_req        (drain_req),
        .drain_done       (drain_done),
        .client_not_empty (client_not_empty),
        .all_idle         (all_idle),
        .err_underflow    (err_underflow)
`ifdef CCI_MPF_RD_ARB_STATS_EN
        ,
        .stats_sel        (stats_sel),
        .stats_grants     (stats_grants)
`endif
    );

    typedef struct {
        int         due;
        logic [W-1:0] data;
        logic [1:0] len;
        t_client_id id;
    } t_exp;

    t_exp sb[$];
    t_exp mon_e;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;

    // Behavioural model state.
    int            m_cnt [N];
    int            m_gcnt[N];
    int            m_ptr;
    t_rd_arb_state m_state;
    bit            m_outv, m_err;
    bit            e_dd, e_idle, e_err;
    bit [N-1:0]    e_cne;

    // Client and environment stimulus.
    bit           c_valid[N];
    logic [W-1:0] c_data [N];
    logic [1:0]   c_len  [N];
    bit           afull, rsp_v;
    int           rsp_id;
    int           last_gid;
    logic [N-1:0] last_gnt;
    int           dut_grants;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Output monitor: each due scoreboard entry must appear on the FIU side.
    always @(negedge clk) begin
        if (mon_en) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                mon_e = sb.pop_front();
                check("out_valid",     ifc.out_valid,     1);
                check("out_data",      ifc.out_data,      mon_e.data);
                check("out_cl_len",    ifc.out_cl_len,    mon_e.len);
                check("out_client_id", ifc.out_client_id, mon_e.id);
            end else begin
                check("out_valid_idle", ifc.out_valid, 0);
            end
        end
    end

    function automatic logic [1:0] rand_len();
        logic [1:0] l;
        do l = 2'($urandom_range(3, 0)); while (l == CL_LEN_ILLEGAL);
        return l;
    endfunction

    task automatic new_req(input int i, input logic [1:0] len);
        c_valid[i] = 1'b1;
        c_data[i]  = {$urandom, $urandom};
        c_len[i]   = len;
    endtask

    task automatic clear_clients();
        for (int i = 0; i < N; i++) begin
            c_valid[i] = 1'b0;
            c_data[i]  = '0;
            c_len[i]   = '0;
        end
    endtask

    // One clock: drive inputs, check grant and status against the model, advance the model.
    task automatic step();
        int gid;
        int idx;
        bit all_zero;
        logic [N-1:0] egnt;
        for (int i = 0; i < N; i++) begin
            ifc.req_valid[i]  = c_valid[i];
            ifc.req_data[i]   = c_data[i];
            ifc.req_cl_len[i] = c_len[i];
        end
        ifc.fiu_almost_full = afull;
        ifc.rsp_valid       = rsp_v;
        ifc.rsp_client_id   = 2'(rsp_id);
        #1;
        gid = -1;
        if (!reset && m_state == RUN && !afull) begin
            for (int k = 0; k < N && gid < 0; k++) begin
                idx = (m_ptr + k) % N;
                if (c_valid[idx] && (m_cnt[idx] + int'(c_len[idx]) + 1 <= MAX)) gid = idx;
            end
        end
        egnt = '0;
        if (gid >= 0) egnt[gid] = 1'b1;
        check("req_grant", ifc.req_grant, egnt);
        last_gnt = ifc.req_grant;
        if (|ifc.req_grant) dut_grants++;
        if (mon_en) begin
            check("drain_done",       drain_done,       e_dd);
            check("client_not_empty", client_not_empty, e_cne);
            check("all_idle",         all_idle,         e_idle);
            check("err_underflow",    err_underflow,    e_err);
        end
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                m_cnt[i]  = 0;
                m_gcnt[i] = 0;
            end
            m_ptr = 0; m_state = RUN; m_outv = 0; m_err = 0;
            e_dd = 0; e_cne = '0; e_idle = 1; e_err = 0;
        end else begin
            all_zero = 1;
            for (int i = 0; i < N; i++) begin
                if (m_cnt[i] != 0) all_zero = 0;
                e_cne[i] = (m_cnt[i] != 0);
            end
            e_dd   = (m_state == DRAINED);
            e_idle = all_zero && !m_outv;
            case (m_state)
                RUN:     if (drain_req) m_state = DRAIN;
                DRAIN:   if (all_zero && !m_outv) m_state = DRAINED;
                DRAINED: if (!drain_req) m_state = RUN;
                default: m_state = RUN;
            endcase
            if (rsp_v) begin
                if (m_cnt[rsp_id] == 0) m_err = 1;
                else                    m_cnt[rsp_id]--;
            end
            if (gid >= 0) begin
                m_cnt[gid] += int'(c_len[gid]) + 1;
                m_gcnt[gid]++;
                m_ptr = (gid + 1) % N;
                sb.push_back('{cyc + 1, c_data[gid], c_len[gid], t_client_id'(gid)});
            end
            e_err  = m_err;
            m_outv = (gid >= 0);
        end
        last_gid = gid;
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) step();
        reset  = 1'b0;
        mon_en = 1'b1;
    endtask

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int g;
        bit seen;
        reset = 1'b1; drain_req = 1'b0; afull = 1'b0; rsp_v = 1'b0; rsp_id = 0;
`ifdef CCI_MPF_RD_ARB_STATS_EN
        stats_sel = '0;
`endif
        clear_clients();
        @(negedge clk);
        do_reset(3);

        // Saturation: four clients, single lines, no responses.
        for (int i = 0; i < N; i++) new_req(i, 2'd0);
        dut_grants = 0;
        for (int t = 0; t < 520; t++) begin
            step();
            if (t < 5) check("rr_order", last_gnt, 4'b0001 << (t % 4));
            if (last_gid >= 0) new_req(last_gid, 2'd0);
        end
        check("saturate_grants", dut_grants, 512);
        check("saturate_no_grant", last_gnt, 0);

        // Credit boundary for a four-line burst.
        do_reset(2);
        clear_clients();
        new_req(0, 2'd0);
        repeat (126) begin
            step();
            if (last_gid == 0) new_req(0, 2'd0);
        end
        new_req(0, 2'd3);
        step();
        check("credit_126_len3", last_gnt, 0);
        rsp_v = 1'b1; rsp_id = 0;
        step(); step();
        rsp_v = 1'b0;
        step();
        check("credit_124_len3", last_gnt, 4'b0001);
        new_req(0, 2'd0);
        step();
        check("credit_full_128", last_gnt, 0);

        // Almost-full blocks grants; release resumes at the pointer.
        do_reset(2);
        clear_clients();
        for (int i = 0; i < N; i++) new_req(i, 2'd0);
        repeat (2) begin
            step();
            if (last_gid >= 0) new_req(last_gid, 2'd0);
        end
        afull = 1'b1; g = 0;
        repeat (10) begin
            step();
            if (|last_gnt) g++;
        end
        check("afull_block", g, 0);
        afull = 1'b0;
        step();
        check("afull_release", last_gnt, 4'b0100);

        // Same-cycle grant and response, then underflow.
        do_reset(2);
        clear_clients();
        new_req(2, 2'd0);
        repeat (5) begin
            step();
            if (last_gid == 2) new_req(2, 2'd0);
        end
        new_req(2, 2'd1);
        rsp_v = 1'b1; rsp_id = 2;
        step();
        check("same_cycle_grant", last_gnt, 4'b0100);
        c_valid[2] = 1'b0;
        repeat (5) step();
        rsp_v = 1'b0;
        step(); step();
        check("net_count_one_left", client_not_empty[2], 1);
        rsp_v = 1'b1;
        step();
        rsp_v = 1'b0;
        step(); step();
        check("net_count_empty", client_not_empty[2], 0);
        rsp_v = 1'b1; rsp_id = 1;
        step();
        rsp_v = 1'b0;
        step();
        check("underflow_set", err_underflow, 1);
        repeat (3) step();
        check("underflow_sticky", err_underflow, 1);

        // Drain with eight lines outstanding.
        do_reset(2);
        clear_clients();
        new_req(0, 2'd3);
        new_req(1, 2'd3);
        repeat (2) begin
            step();
            if (last_gid >= 0) c_valid[last_gid] = 1'b0;
        end
        drain_req = 1'b1;
        step();
        for (int i = 0; i < N; i++) new_req(i, 2'd0);
        g = 0;
        repeat (4) begin
            step();
            if (|last_gnt) g++;
        end
        for (int r = 0; r < 8; r++) begin
            rsp_v = 1'b1; rsp_id = r % 2;
            step();
            if (|last_gnt) g++;
        end
        rsp_v = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            step();
            if (|last_gnt) g++;
            if (drain_done === 1'b1) seen = 1'b1;
        end
        check("drain_no_grant", g, 0);
        check("drain_done_seen", seen, 1);
        drain_req = 1'b0;
        g = 0;
        repeat (5) begin
            step();
            if (|last_gnt) g++;
            if (last_gid >= 0) c_valid[last_gid] = 1'b0;
        end
        check("drain_resume", g > 0, 1);

`ifdef CCI_MPF_RD_ARB_STATS_EN
        // Grant statistics readback.
        do_reset(2);
        clear_clients();
        new_req(3, 2'd0);
        repeat (3) begin
            step();
            if (last_gid == 3) new_req(3, 2'd0);
        end
        c_valid[3] = 1'b0;
        stats_sel = 2'd3;
        step();
        check("stats_grants", stats_grants, 3);
`endif

        // Randomised traffic with responses, almost-full, drains and a mid-run reset.
        do_reset(2);
        clear_clients();
        for (int t = 0; t < 4000; t++) begin
            int j;
            for (int i = 0; i < N; i++) begin
                if (!c_valid[i] && $urandom_range(1, 0) == 1) new_req(i, rand_len());
            end
            afull = ($urandom_range(7, 0) == 0);
            if ($urandom_range(199, 0) == 0) drain_req = !drain_req;
            rsp_v = 1'b0;
            if ($urandom_range(3, 0) != 0) begin
                j = $urandom_range(N - 1, 0);
                if (m_cnt[j] > 0) begin
                    rsp_v  = 1'b1;
                    rsp_id = j;
                end
            end
            if (t == 2000) reset = 1'b1;
            if (t == 2002) reset = 1'b0;
            step();
            if (last_gid >= 0) c_valid[last_gid] = 1'b0;
        end

        drain_req = 1'b0; afull = 1'b0; rsp_v = 1'b0;
        clear_clients();
        repeat (4) step();
        check("scoreboard_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
